// File: rtl/cnn_window_ctrl.sv
// cnn_window_ctrl: sequences a raster pixel stream into a K-tap line buffer and flags complete KxK windows.
// Latency: shift_en/shiftin/win_valid are registered, one cycle after each accepted pixel.
// Backpressure: in_ready is high only in RUN; in_valid low simply stalls the counters and outputs.
// Optional feature: define CNN_WIN_STRIDE2_EN to flag only windows whose top-left row and column are both even.
module cnn_window_ctrl #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 5,
  parameter int DW    = 9
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DW-1:0]       in_data,
  output logic                       shift_en,
  output logic signed [DW-1:0]       shiftin,
  output logic                       win_valid,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [RW-1:0]        row_q, row_d;
  logic [CW-1:0]        col_q, col_d;
  logic                 shift_en_q;
  logic signed [DW-1:0] shiftin_q;
  logic                 win_valid_q;
  logic [RW-1:0]        win_row_q;
  logic [CW-1:0]        win_col_q;

  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          last_px;
  logic          win_hit;
  logic          win_hit_s;
  logic [RW-1:0] row_off;
  logic [CW-1:0] col_off;

  // Pixel position decode: window-complete test and top-left offset of the window.
  assign accept   = in_valid & in_ready;
  assign col_last = (col_q == CW'(IMG_W - 1));
  assign row_last = (row_q == RW'(IMG_H - 1));
  assign last_px  = col_last & row_last;
  assign win_hit  = (row_q >= RW'(K - 1)) & (col_q >= CW'(K - 1));
  assign row_off  = row_q - RW'(K - 1);
  assign col_off  = col_q - CW'(K - 1);

`ifdef CNN_WIN_STRIDE2_EN
  assign win_hit_s = win_hit & ~row_off[0] & ~col_off[0];
`else
  assign win_hit_s = win_hit;
`endif

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: start only counts in IDLE; the final pixel's acceptance ends the frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (accept && last_px) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state: ready only in RUN, DONE doubles as the frame_done cycle.
  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      S_IDLE:  ;
      S_RUN:   begin in_ready = 1'b1; busy = 1'b1; end
      S_DONE:  begin busy = 1'b1; frame_done = 1'b1; end
      default: ;
    endcase
  end

  // Raster position: cleared by a start seen in IDLE, advanced once per accepted pixel.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (state_q == S_IDLE && start) begin
      row_d = '0;
      col_d = '0;
    end else if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  // Line-buffer feed and window flag, both one cycle behind the acceptance; values hold when idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_en_q  <= 1'b0;
      shiftin_q   <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      shift_en_q  <= accept;
      win_valid_q <= accept & win_hit_s;
      if (accept) begin
        shiftin_q <= in_data;
      end
      if (accept && win_hit_s) begin
        win_row_q <= row_off;
        win_col_q <= col_off;
      end
    end
  end

  assign shift_en  = shift_en_q;
  assign shiftin   = shiftin_q;
  assign win_valid = win_valid_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;

endmodule

// File: tb/tb_cnn_window_ctrl.sv
// Testbench for cnn_window_ctrl: scoreboard of per-pixel expectations from a raster-index model.
// Driver updates inputs on the falling edge; monitor compares DUT outputs on the falling edge.
// Covers reset, idle in_valid, continuous/toggled/random frames, mid-frame reset and ignored starts.
module tb_cnn_window_ctrl;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K     = 5;
  localparam int DW    = 9;
`ifdef CNN_WIN_STRIDE2_EN
  localparam int STR = 2;
`else
  localparam int STR = 1;
`endif
  localparam int NPIX      = IMG_W * IMG_H;
  localparam int NWR       = (IMG_H - K) / STR + 1;
  localparam int NWC       = (IMG_W - K) / STR + 1;
  localparam int NWIN      = NWR * NWC;
  localparam int LASTR     = (NWR - 1) * STR;
  localparam int LASTC     = (NWC - 1) * STR;
  localparam int FIRST_N   = (K - 1) * IMG_W + K;
  localparam bit LAST_WIN  = ((IMG_H - K) % STR == 0) && ((IMG_W - K) % STR == 0);

  logic                       clk;
  logic                       rstn;
  logic                       start;
  logic                       in_valid;
  logic                       in_ready;
  logic signed [DW-1:0]       in_data;
  logic                       shift_en;
  logic signed [DW-1:0]       shiftin;
  logic                       win_valid;
  logic [$clog2(IMG_H)-1:0]   win_row;
  logic [$clog2(IMG_W)-1:0]   win_col;
  logic                       busy;
  logic                       frame_done;

  cnn_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .shift_en(shift_en), .shiftin(shiftin),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
    .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [DW-1:0] d;
    bit                   win;
    int                   wr;
    int                   wc;
    bit                   last;
    int                   idx;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  // model state: 0 idle, 1 run, 2 done; n = pixels accepted this frame
  int m_st = 0;
  int n = 0;

  // monitor statistics for the current frame
  int win_cnt = 0;
  int sh_cnt = 0;
  int fd_cnt = 0;
  int first_n = -1;
  int last_r = -1;
  int last_c = -1;
  bit fd_with_win = 1'b0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_shift_en"}, shift_en, 0);
    check({tag, "_shiftin"}, shiftin, 0);
    check({tag, "_win_valid"}, win_valid, 0);
    check({tag, "_win_row"}, win_row, 0);
    check({tag, "_win_col"}, win_col, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  // Monitor: every shift_en consumes one scoreboard entry; window/done flags only ride on shift_en.
  always @(negedge clk) begin
    exp_t e;
    if (rstn === 1'b1) begin
      if (shift_en === 1'b1) begin
        sh_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_shift_en", 1, 0);
        end else begin
          e = sb.pop_front();
          check("shiftin", shiftin, e.d);
          check("win_valid", win_valid, e.win);
          check("frame_done", frame_done, e.last);
          if (e.win) begin
            check("win_row", win_row, e.wr);
            check("win_col", win_col, e.wc);
            if (win_cnt == 0) first_n = e.idx + 1;
            last_r = win_row;
            last_c = win_col;
            win_cnt++;
          end
        end
        if (frame_done === 1'b1) begin
          fd_cnt++;
          fd_with_win = win_valid;
        end
      end else if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
        check("win_valid_without_shift", win_valid, 0);
        check("frame_done_without_shift", frame_done, 0);
        if (frame_done === 1'b1) fd_cnt++;
      end
    end
  end

  // One clock of stimulus; the model decides acceptance from frame position, not from DUT state.
  task automatic cycle(input bit v, input bit st);
    exp_t e;
    int r;
    int c;
    @(negedge clk);
    in_valid = v;
    start    = st;
    in_data  = DW'($urandom);
    #1;
    check("in_ready", in_ready, (m_st == 1));
    check("busy", busy, (m_st != 0));
    if (m_st == 1 && v) begin
      r     = n / IMG_W;
      c     = n % IMG_W;
      e.d   = in_data;
      e.win = (r >= K - 1) && (c >= K - 1) && ((r - K + 1) % STR == 0) && ((c - K + 1) % STR == 0);
      e.wr  = r - K + 1;
      e.wc  = c - K + 1;
      e.last = (n == NPIX - 1);
      e.idx = n;
      sb.push_back(e);
      n++;
      if (e.last) m_st = 2;
    end else if (m_st == 0) begin
      if (st) begin
        m_st = 1;
        n = 0;
      end
    end else if (m_st == 2) begin
      m_st = 0;
    end
  endtask

  task automatic clear_stats();
    win_cnt = 0;
    sh_cnt = 0;
    fd_cnt = 0;
    first_n = -1;
    last_r = -1;
    last_c = -1;
    fd_with_win = 1'b0;
  endtask

  // mode 0: continuous, 1: valid pattern 1,0,0,1, 2: random; abort_at>0 stops after that many pixels
  task automatic run_frame(input int mode, input bit extra_start, input int abort_at);
    int i;
    bit v;
    bit st;
    i = 0;
    clear_stats();
    cycle(1'b0, 1'b1);
    while (m_st != 0 && i < 20000) begin
      if (abort_at > 0 && n == abort_at) break;
      case (mode)
        0:       v = 1'b1;
        1:       v = (i % 4 == 0) || (i % 4 == 3);
        default: v = 1'($urandom_range(0, 1));
      endcase
      st = extra_start && ((m_st == 1 && n == 50) || m_st == 2);
      cycle(v, st);
      i++;
    end
    if (i >= 20000) check("frame_timeout", 1, 0);
    if (abort_at == 0) repeat (3) cycle(1'b0, 1'b0);
  endtask

  task automatic frame_checks();
    check("win_count", win_cnt, NWIN);
    check("shift_count", sh_cnt, NPIX);
    check("frame_done_count", fd_cnt, 1);
    check("first_win_pixel", first_n, FIRST_N);
    check("last_win_row", last_r, LASTR);
    check("last_win_col", last_c, LASTC);
    check("frame_done_with_win", fd_with_win, LAST_WIN);
    check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    rstn     = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rstn = 1'b1;

    // in_valid high while idle must not be accepted
    clear_stats();
    repeat (10) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check("idle_shift_count", sh_cnt, 0);

    run_frame(0, 1'b0, 0);
    frame_checks();

    run_frame(1, 1'b0, 0);
    frame_checks();

    // reset mid-frame after 300 accepted pixels
    run_frame(0, 1'b0, 300);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 check_zero("midreset");
    repeat (3) begin
      @(negedge clk);
      check_zero("midreset_hold");
    end
    sb.delete();
    m_st = 0;
    n = 0;
    in_valid = 1'b1;
    start = 1'b0;
    #2 rstn = 1'b1;
    check("abort_frame_done", fd_cnt, 0);
    repeat (3) cycle(1'b1, 1'b0);
    run_frame(0, 1'b0, 0);
    frame_checks();

    // stray starts at pixel 50 and in the DONE cycle
    run_frame(0, 1'b1, 0);
    frame_checks();
    repeat (5) cycle(1'b1, 1'b0);
    check("stray_start_frame_done", fd_cnt, 1);

    run_frame(2, 1'b0, 0);
    frame_checks();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cnn_window_ctrl.md
CNN_WINDOW_CTRL -- requirements
Module: cnn_window_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 28: image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 28: image height in pixels.
REQ-003 SHALL have parameter K, default 5: window size, equal to the line-buffer tap count.
REQ-004 SHALL have parameter DW, default 9: pixel width in bits, signed.
REQ-005 SHALL have clk  in  1: single clock; all logic is on the rising edge.
REQ-006 SHALL have rstn  in  1: asynchronous, active-low reset.
REQ-007 SHALL have start  in  1: one-cycle pulse that begins a frame.
REQ-008 SHALL have in_valid / in_ready  in / out  1 / 1: pixel handshake; a pixel is accepted when both are high.
REQ-009 SHALL have in_data  in  DW: raster-order pixel.
REQ-010 SHALL have shift_en  out  1: clock enable to the line buffer.
REQ-011 SHALL have shiftin  out  DW: registered pixel to the line buffer.
REQ-012 SHALL have win_valid  out  1: taps hold a complete KxK window.
REQ-013 SHALL have win_row / win_col  out  clog2(IMG_H) / clog2(IMG_W): top-left coordinate of the window.
REQ-014 SHALL have busy  out  1: high during a frame.
REQ-015 SHALL have frame_done  out  1: one-cycle pulse at the end of a frame.

Function
REQ-016 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE on acceptance of pixel (IMG_H-1, IMG_W-1); DONE -> IDLE after one cycle.
REQ-017 SHALL drive in_ready=1 only in RUN; in IDLE and DONE, in_valid is ignored and no pixel is accepted.
REQ-018 SHALL hold col counter 0..IMG_W-1 and row counter 0..IMG_H-1, both cleared on start; col increments per accepted pixel; at IMG_W-1, col wraps to 0 and row increments.
REQ-019 SHALL register in_data into shiftin and assert shift_en for exactly one cycle, the cycle after each acceptance; with no acceptance, shift_en=0 and shiftin holds.
REQ-020 SHALL, for an accepted pixel at (r,c) with r>=K-1 and c>=K-1, assert win_valid in the same cycle as its shift_en, with win_row=r-K+1 and win_col=c-K+1; otherwise win_valid=0.
REQ-021 SHALL produce (IMG_H-K+1)*(IMG_W-K+1) win_valid pulses per frame, with no duplicates under backpressure.
REQ-022 SHALL drive busy=1 in RUN and DONE.
REQ-023 SHALL pulse frame_done in the DONE cycle, coincident with the shift_en/win_valid of the last pixel.
REQ-024 SHALL ignore start while busy=1, with no counter disturbance.
REQ-025 SHALL not flush the line buffer between frames; stale taps are never flagged because REQ-020 requires r>=K-1 within the current frame.
REQ-026 SHALL sample start arriving in the DONE cycle as ignored; a new frame requires start in IDLE.
REQ-027 SHALL keep output state unchanged when in_valid is low in RUN.

Reset
REQ-028 SHALL on rstn=0 immediately force state=IDLE, col=row=0, shiftin=0, shift_en=0, win_valid=0, win_row=win_col=0, busy=0, frame_done=0, in_ready=0.
REQ-029 SHALL on reset mid-frame discard the partial frame, with no frame_done; the next frame starts only on a new start after rstn rises.

Configuration
REQ-030 SHALL, when macro CNN_WIN_STRIDE2_EN is defined, additionally require that (r-K+1) and (c-K+1) are both even for win_valid, giving ((IMG_H-K)/2+1)*((IMG_W-K)/2+1) windows per frame; when undefined, stride is 1 per REQ-020.

Verification
REQ-031 SHALL cover: defaults, start, then continuous in_valid -> first win_valid with the 117th accepted pixel at win_row=0/win_col=0; 576 pulses total; last at (23,23) together with frame_done.
REQ-032 SHALL cover: in_valid toggling 1,0,0,1 repeatedly -> shift_en count=784, win_valid count=576, coordinates identical to continuous run.
REQ-033 SHALL cover: rstn low after 300 accepted pixels, then start -> all outputs 0 during reset, no frame_done, first win_valid again after 117 pixels.
REQ-034 SHALL cover: start pulsed at pixel 50 and during DONE -> ignored; exactly one frame_done; win count 576.
REQ-035 SHALL cover: CNN_WIN_STRIDE2_EN defined, defaults -> 144 win_valid pulses, coordinates (0,0),(0,2)..(22,22).
REQ-036 SHALL cover: in_valid=1 while IDLE -> in_ready=0, shift_en=0, counters remain 0.
